// File: rtl/booth_product_accumulator.sv
// Frame accumulator for signed 16-bit Booth products: sums NUM_TERMS accepted products with
// saturation and presents each frame sum on a registered valid/ready output.
module booth_product_accumulator #(
  parameter int unsigned ACC_W     = 24,
  parameter int unsigned NUM_TERMS = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_sat
);

  localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] Terms  = CNT_W'(NUM_TERMS);

  typedef enum logic [0:0] {StAccum, StDrain} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               sat_q, sat_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic               out_sat_q, out_sat_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [ACC_W:0]     sum_wide;
  logic               ovf_pos, ovf_neg;
  logic [ACC_W-1:0]   acc_next;
  logic               sat_next;

  // One guard bit: overflow shows up as the top two bits disagreeing.
  always_comb begin
    sum_wide = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-15){in_product[15]}}, in_product};
    ovf_pos  = ~sum_wide[ACC_W] & sum_wide[ACC_W-1];
    ovf_neg  = sum_wide[ACC_W] & ~sum_wide[ACC_W-1];
    if (ovf_pos) begin
      acc_next = AccMax;
    end else if (ovf_neg) begin
      acc_next = AccMin;
    end else begin
      acc_next = sum_wide[ACC_W-1:0];
    end
    sat_next = sat_q | ovf_pos | ovf_neg;
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    sat_d     = sat_q;
    out_sum_d = out_sum_q;
    out_sat_d = out_sat_q;
    if (clear) begin
      state_d   = StAccum;
      acc_d     = '0;
      count_d   = '0;
      sat_d     = 1'b0;
      out_sum_d = '0;
      out_sat_d = 1'b0;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (in_valid && in_ready_q) begin
            acc_d   = acc_next;
            sat_d   = sat_next;
            count_d = count_q + 1'b1;
            if (count_d == Terms) begin
              state_d   = StDrain;
              out_sum_d = acc_next;
              out_sat_d = sat_next;
            end
          end
        end
        StDrain: begin
          if (out_valid_q && out_ready) begin
            state_d = StAccum;
            acc_d   = '0;
            count_d = '0;
            sat_d   = 1'b0;
          end
        end
        default: state_d = StAccum;
      endcase
    end
    // Handshake flags are registered copies of the next state, so no input reaches an output.
    in_ready_d  = (state_d == StAccum);
    out_valid_d = (state_d == StDrain);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StAccum;
      acc_q       <= '0;
      count_q     <= '0;
      sat_q       <= 1'b0;
      out_sum_q   <= '0;
      out_sat_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      sat_q       <= sat_d;
      out_sum_q   <= out_sum_d;
      out_sat_q   <= out_sat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Directed bench: default instance (24-bit, 4 terms) and a saturation instance (18-bit, 8 terms).
module tb_booth_product_accumulator;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_sat;
  logic [15:0] a_in_product;
  logic [23:0] a_out_sum;
  logic        b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sat;
  logic [15:0] b_in_product;
  logic [17:0] b_out_sum;

  int checks = 0;
  int failures = 0;
  int frames_seen;
  int stall_cycles;

  booth_product_accumulator dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (a_clear),
    .in_valid   (a_in_valid),
    .in_ready   (a_in_ready),
    .in_product (a_in_product),
    .out_valid  (a_out_valid),
    .out_ready  (a_out_ready),
    .out_sum    (a_out_sum),
    .out_sat    (a_out_sat)
  );

  booth_product_accumulator #(.ACC_W(18), .NUM_TERMS(8)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (b_clear),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .in_product (b_in_product),
    .out_valid  (b_out_valid),
    .out_ready  (b_out_ready),
    .out_sum    (b_out_sum),
    .out_sat    (b_out_sat)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one product on A for one edge (called at a negedge, returns at the next negedge).
  task automatic a_send(input int v);
    a_in_valid   = 1'b1;
    a_in_product = 16'(v);
    @(negedge clk);
    a_in_valid   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    a_clear = 1'b0; a_in_valid = 1'b0; a_in_product = '0; a_out_ready = 1'b1;
    b_clear = 1'b0; b_in_valid = 1'b0; b_in_product = '0; b_out_ready = 1'b1;

    // 1. Reset
    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(a_out_valid), 0);
    chk("rst_out_sum", int'($signed(a_out_sum)), 0);
    chk("rst_in_ready", int'(a_in_ready), 0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_before_edge", int'(a_in_ready), 0);
    @(negedge clk);
    chk("rel_in_ready_a", int'(a_in_ready), 1);
    chk("rel_in_ready_b", int'(b_in_ready), 1);

    // 2. Basic frame: 100 - 50 + 16384 - 16256 = 178
    a_send(100);
    a_send(-50);
    a_send(16384);
    chk("mid_frame_no_valid", int'(a_out_valid), 0);
    a_send(-16256);
    chk("f1_out_valid", int'(a_out_valid), 1);
    chk("f1_out_sum", int'($signed(a_out_sum)), 178);
    chk("f1_out_sat", int'(a_out_sat), 0);
    chk("f1_in_ready_low", int'(a_in_ready), 0);
    @(negedge clk);
    chk("f1_in_ready_back", int'(a_in_ready), 1);
    chk("f1_valid_dropped", int'(a_out_valid), 0);

    // 3. Backpressure with in_valid=1 carrying 7
    a_out_ready = 1'b0;
    a_send(1);
    a_send(2);
    a_send(3);
    a_send(4);
    chk("bp_out_valid", int'(a_out_valid), 1);
    a_in_valid = 1'b1;
    a_in_product = 16'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_sum_stable", int'($signed(a_out_sum)), 10);
      chk("bp_in_ready", int'(a_in_ready), 0);
      chk("bp_valid_held", int'(a_out_valid), 1);
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", int'(a_out_valid), 0);
    a_out_ready = 1'b0;
    a_send(5);
    a_send(5);
    a_send(5);
    a_send(5);
    chk("bp_next_frame_sum", int'($signed(a_out_sum)), 20);
    a_out_ready = 1'b1;
    @(negedge clk);

    // 4. Saturation on B (ACC_W=18, NUM_TERMS=8)
    b_in_valid = 1'b1;
    b_in_product = 16'd16384;
    repeat (8) @(negedge clk);
    b_in_valid = 1'b0;
    chk("satA_valid", int'(b_out_valid), 1);
    chk("satA_sum", int'($signed(b_out_sum)), 131071);
    chk("satA_sat", int'(b_out_sat), 1);
    @(negedge clk);
    b_in_valid = 1'b1;
    b_in_product = 16'h8000;
    repeat (8) @(negedge clk);
    b_in_valid = 1'b0;
    chk("satB_sum", int'($signed(b_out_sum)), -131072);
    chk("satB_sat", int'(b_out_sat), 1);
    @(negedge clk);
    b_in_valid = 1'b1;
    b_in_product = 16'(-16384);
    repeat (8) @(negedge clk);
    b_in_valid = 1'b0;
    chk("satC_sum", int'($signed(b_out_sum)), -131072);
    chk("satC_sat", int'(b_out_sat), 0);
    @(negedge clk);

    // 5. Clear mid-frame drops the simultaneous 9
    a_send(500);
    a_send(500);
    a_clear = 1'b1;
    a_send(9);
    a_clear = 1'b0;
    chk("clr_out_sum_zero", int'($signed(a_out_sum)), 0);
    chk("clr_in_ready", int'(a_in_ready), 1);
    a_send(1);
    a_send(2);
    a_send(3);
    a_send(4);
    chk("clr_out_valid", int'(a_out_valid), 1);
    chk("clr_out_sum", int'($signed(a_out_sum)), 10);
    chk("clr_out_sat", int'(a_out_sat), 0);
    @(negedge clk);

    // 6. Back-to-back frames, 12 products of 1
    frames_seen = 0;
    stall_cycles = 0;
    a_in_valid = 1'b1;
    a_in_product = 16'd1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (a_out_valid) begin
        frames_seen++;
        chk("b2b_sum", int'($signed(a_out_sum)), 4);
      end
      if (!a_in_ready) stall_cycles++;
    end
    a_in_valid = 1'b0;
    chk("b2b_frames", frames_seen, 3);
    chk("b2b_stalls", stall_cycles, 3);
    @(negedge clk);

    // Asynchronous reset mid-frame discards partial state
    a_send(3);
    a_send(3);
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", int'(a_in_ready), 0);
    chk("arst_out_sum", int'($signed(a_out_sum)), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a_send(1);
    a_send(1);
    a_send(1);
    a_send(1);
    chk("arst_fresh_frame", int'($signed(a_out_sum)), 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
